// File: rtl/video_timing_pkg.sv
// Shared constants, pixel types and FSM encoding for the raster timing generator.
package video_timing_pkg;

    localparam int COORD_W = 11;
    localparam int RGB_W   = 24;

    typedef logic [COORD_W-1:0] coord_t;
    typedef logic [RGB_W-1:0]   rgb_t;

    // 1280x720@60 CEA timing, 74.25 MHz pixel clock
    localparam int H_SYNC_720P  = 40;
    localparam int H_BACK_720P  = 220;
    localparam int H_DISP_720P  = 1280;
    localparam int H_FRONT_720P = 110;
    localparam int V_SYNC_720P  = 5;
    localparam int V_BACK_720P  = 20;
    localparam int V_DISP_720P  = 720;
    localparam int V_FRONT_720P = 5;

    localparam rgb_t RGB_BLACK = 24'h000000;
    localparam rgb_t RGB_WHITE = 24'hFFFFFF;
    localparam rgb_t RGB_RED   = 24'hFF0000;
    localparam rgb_t RGB_GREEN = 24'h00FF00;
    localparam rgb_t RGB_BLUE  = 24'h0000FF;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } vt_state_e;

    function automatic logic in_window(coord_t value, int lo, int hi);
        return (int'(value) >= lo) && (int'(value) < hi);
    endfunction

endpackage

// File: rtl/video_timing_if.sv
// Pixel-request / video-output bundle between the timing driver and the display stage.
interface video_timing_if;
    import video_timing_pkg::*;

    logic   run;
    rgb_t   pixel_data;
    logic   data_req;
    coord_t pixel_xpos;
    coord_t pixel_ypos;
    logic   video_hs;
    logic   video_vs;
    logic   video_de;
    rgb_t   video_rgb;
    logic   frame_start;
    logic   busy;

    modport master (
        input  run, pixel_data,
        output data_req, pixel_xpos, pixel_ypos, video_hs, video_vs,
               video_de, video_rgb, frame_start, busy
    );

    modport slave (
        output run, pixel_data,
        input  data_req, pixel_xpos, pixel_ypos, video_hs, video_vs,
               video_de, video_rgb, frame_start, busy
    );
endinterface

// File: rtl/video_axis_counter.sv
// Modulo-MODULUS counter with synchronous clear and terminal-count flag; one per raster axis.
module video_axis_counter #(
    parameter int WIDTH   = 11,
    parameter int MODULUS = 1650
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             en,
    output logic [WIDTH-1:0] cnt,
    output logic             tc
);
    localparam logic [WIDTH-1:0] LAST = WIDTH'(MODULUS - 1);

    logic [WIDTH-1:0] cnt_q, cnt_d;

    assign cnt = cnt_q;
    assign tc  = (cnt_q == LAST);

    always_comb begin
        // NOTE: default first so every path assigns cnt_d and no latch is inferred.
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en) begin
            cnt_d = tc ? '0 : cnt_q + WIDTH'(1);
        end
    end

    // NOTE: sequential state uses non-blocking assignment so all flops update together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/video_timing_driver.sv
// Raster timing generator: counters, syncs, data-enable and a one-cycle-early pixel request.
module video_timing_driver
    import video_timing_pkg::*;
#(
    parameter int H_SYNC   = H_SYNC_720P,
    parameter int H_BACK   = H_BACK_720P,
    parameter int H_DISP   = H_DISP_720P,
    parameter int H_FRONT  = H_FRONT_720P,
    parameter int V_SYNC   = V_SYNC_720P,
    parameter int V_BACK   = V_BACK_720P,
    parameter int V_DISP   = V_DISP_720P,
    parameter int V_FRONT  = V_FRONT_720P,
    parameter bit SYNC_POL = 1'b1
) (
    input  logic           pixel_clk,
    input  logic           sys_rst_n,
    video_timing_if.master vif
);
    localparam int H_TOTAL  = H_SYNC + H_BACK + H_DISP + H_FRONT;
    localparam int V_TOTAL  = V_SYNC + V_BACK + V_DISP + V_FRONT;
    localparam int H_ACT_LO = H_SYNC + H_BACK;
    localparam int H_ACT_HI = H_ACT_LO + H_DISP;
    localparam int V_ACT_LO = V_SYNC + V_BACK;
    localparam int V_ACT_HI = V_ACT_LO + V_DISP;
    localparam coord_t X_OFFSET = coord_t'(H_ACT_LO - 1);
    localparam coord_t Y_OFFSET = coord_t'(V_ACT_LO);

    vt_state_e state_q, state_d;
    coord_t    h_cnt, v_cnt;
    logic      h_tc, v_tc, cnt_en, frame_end;
    logic      active, hs_act, vs_act, h_act, v_act, h_req, req, de;

    assign cnt_en    = (state_q != IDLE);
    assign frame_end = h_tc & v_tc;

    // Counters sit at 0 while idle so the first RUN cycle is h=0, v=0.
    video_axis_counter #(.WIDTH(COORD_W), .MODULUS(H_TOTAL)) u_h_cnt (
        .clk   (pixel_clk),
        .rst_n (sys_rst_n),
        .clr   (!cnt_en),
        .en    (cnt_en),
        .cnt   (h_cnt),
        .tc    (h_tc)
    );

    video_axis_counter #(.WIDTH(COORD_W), .MODULUS(V_TOTAL)) u_v_cnt (
        .clk   (pixel_clk),
        .rst_n (sys_rst_n),
        .clr   (!cnt_en),
        .en    (cnt_en & h_tc),
        .cnt   (v_cnt),
        .tc    (v_tc)
    );

    always_ff @(posedge pixel_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Stopping is only honoured at the frame wrap; DRAIN lets the frame finish.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (vif.run) state_d = RUN;
            RUN: begin
                if (frame_end)     state_d = vif.run ? RUN : IDLE;
                else if (!vif.run) state_d = DRAIN;
            end
            DRAIN: begin
                if (vif.run)        state_d = RUN;
                else if (frame_end) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        active = (state_q != IDLE);
        hs_act = in_window(h_cnt, 0, H_SYNC);
        vs_act = in_window(v_cnt, 0, V_SYNC);
        h_act  = in_window(h_cnt, H_ACT_LO, H_ACT_HI);
        v_act  = in_window(v_cnt, V_ACT_LO, V_ACT_HI);
        h_req  = in_window(h_cnt, H_ACT_LO - 1, H_ACT_HI - 1);
        req    = active & v_act & h_req;
        de     = active & v_act & h_act;
    end

    assign vif.video_hs    = (active & hs_act) ^ ~SYNC_POL;
    assign vif.video_vs    = (active & vs_act) ^ ~SYNC_POL;
    assign vif.video_de    = de;
    assign vif.data_req    = req;
    assign vif.pixel_xpos  = req ? (h_cnt - X_OFFSET) : '0;
    assign vif.pixel_ypos  = req ? (v_cnt - Y_OFFSET) : '0;
    assign vif.video_rgb   = de ? vif.pixel_data : RGB_BLACK;
    assign vif.frame_start = active & (h_cnt == '0) & (v_cnt == '0);
    assign vif.busy        = active;

endmodule

// File: tb/tb_video_timing_driver.sv
// Self-checking bench: small-raster DUT with a registered display model and rgb scoreboard,
// plus a 720p DUT with active-low syncs for sync-width checks.
module tb_video_timing_driver;
    import video_timing_pkg::*;

    localparam int HT = 14;
    localparam int FT = 98;
    localparam int L_LINES = 7;

    typedef struct {
        int          cyc;
        logic [27:0] ctl;
        rgb_t        rgb;
    } vec_t;

    logic pixel_clk = 1'b0;
    logic sys_rst_n = 1'b0;
    int   n_cmp = 0;
    int   n_err = 0;
    rgb_t sb_q[$];

    always #5 pixel_clk = ~pixel_clk;

    video_timing_if bus_s ();
    video_timing_if bus_l ();

    video_timing_driver #(
        .H_SYNC(2), .H_BACK(2), .H_DISP(8), .H_FRONT(2),
        .V_SYNC(1), .V_BACK(1), .V_DISP(4), .V_FRONT(1),
        .SYNC_POL(1'b1)
    ) dut_s (
        .pixel_clk (pixel_clk),
        .sys_rst_n (sys_rst_n),
        .vif       (bus_s)
    );

    video_timing_driver #(.SYNC_POL(1'b0)) dut_l (
        .pixel_clk (pixel_clk),
        .sys_rst_n (sys_rst_n),
        .vif       (bus_l)
    );

    // Display stage: registers {ypos, xpos} one cycle after each request, filler otherwise
    always @(posedge pixel_clk)
        bus_s.pixel_data <= bus_s.data_req ? {2'b00, bus_s.pixel_ypos, bus_s.pixel_xpos} : 24'hA5A5A5;

    assign bus_l.pixel_data = RGB_WHITE;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [27:0] ctl(bit fs, bit busy, bit hs, bit vs, bit de, bit req, int x, int y);
        return {fs, busy, hs, vs, de, req, 11'(x), 11'(y)};
    endfunction

    function automatic logic [27:0] snap_ctl();
        return {bus_s.frame_start, bus_s.busy, bus_s.video_hs, bus_s.video_vs,
                bus_s.video_de, bus_s.data_req, bus_s.pixel_xpos, bus_s.pixel_ypos};
    endfunction

    function automatic vec_t mkv(int c, logic [27:0] k, rgb_t r);
        vec_t v;
        v.cyc = c;
        v.ctl = k;
        v.rgb = r;
        return v;
    endfunction

    // Expected small-raster outputs at cycle i of a running frame
    function automatic logic [27:0] model_ctl(int i);
        int h = i % HT;
        int v = i / HT;
        bit req = (v >= 2) && (v < 6) && (h >= 3) && (h < 11);
        bit de  = (v >= 2) && (v < 6) && (h >= 4) && (h < 12);
        return ctl(i == 0, 1'b1, h < 2, v < 1, de, req, req ? h - 3 : 0, req ? v - 2 : 0);
    endfunction

    task automatic wait_fs(input int budget, output int cycles);
        cycles = -1;
        for (int c = 1; c <= budget; c++) begin
            @(negedge pixel_clk);
            if (bus_s.frame_start) begin
                cycles = c;
                return;
            end
        end
    endtask

    // Starts on a frame_start cycle; returns when the next frame starts or the DUT goes idle
    task automatic walk_frame(input string tag, input int drop_at, input int raise_at,
                              output int len, output int de_n, output bit went_idle);
        int i;
        logic [27:0] m;
        rgb_t exp_rgb;
        de_n = 0;
        for (i = 0; i < 200; i++) begin
            if (i > 0 && (bus_s.frame_start || !bus_s.busy)) break;
            if (i == drop_at)  bus_s.run = 1'b0;
            if (i == raise_at) bus_s.run = 1'b1;
            m = model_ctl(i);
            check({tag, "_ctl"}, snap_ctl(), m);
            exp_rgb = RGB_BLACK;
            if (m[23] && sb_q.size() > 0) exp_rgb = sb_q.pop_front();
            check({tag, "_rgb"}, bus_s.video_rgb, exp_rgb);
            if (m[22]) sb_q.push_back({2'b00, m[10:0], m[21:11]});
            if (bus_s.video_de) de_n++;
            @(negedge pixel_clk);
        end
        len = i;
        went_idle = !bus_s.busy;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout, expected bench completion");
        $fatal(1, "watchdog timeout");
    end

    initial begin
        vec_t vecs[$];
        int   cyc, len, de_n, cur, cnt, bad, hs_low, vs_low;
        bit   idle;

        vecs.push_back(mkv( 0, ctl(1, 1, 1, 1, 0, 0, 0, 0), 24'd0));
        vecs.push_back(mkv( 1, ctl(0, 1, 1, 1, 0, 0, 0, 0), 24'd0));
        vecs.push_back(mkv( 2, ctl(0, 1, 0, 1, 0, 0, 0, 0), 24'd0));
        vecs.push_back(mkv(14, ctl(0, 1, 1, 0, 0, 0, 0, 0), 24'd0));
        vecs.push_back(mkv(17, ctl(0, 1, 0, 0, 0, 0, 0, 0), 24'd0));
        vecs.push_back(mkv(30, ctl(0, 1, 0, 0, 0, 0, 0, 0), 24'd0));
        vecs.push_back(mkv(31, ctl(0, 1, 0, 0, 0, 1, 0, 0), 24'd0));
        vecs.push_back(mkv(32, ctl(0, 1, 0, 0, 1, 1, 1, 0), 24'd0));
        vecs.push_back(mkv(38, ctl(0, 1, 0, 0, 1, 1, 7, 0), 24'd6));
        vecs.push_back(mkv(39, ctl(0, 1, 0, 0, 1, 0, 0, 0), 24'd7));
        vecs.push_back(mkv(40, ctl(0, 1, 0, 0, 0, 0, 0, 0), 24'd0));
        vecs.push_back(mkv(80, ctl(0, 1, 0, 0, 1, 1, 7, 3), 24'((3 << 11) | 6)));
        vecs.push_back(mkv(81, ctl(0, 1, 0, 0, 1, 0, 0, 0), 24'((3 << 11) | 7)));
        vecs.push_back(mkv(85, ctl(0, 1, 1, 0, 0, 0, 0, 0), 24'd0));
        vecs.push_back(mkv(97, ctl(0, 1, 0, 0, 0, 0, 0, 0), 24'd0));

        bus_s.run = 1'b0;
        bus_l.run = 1'b0;
        sys_rst_n = 1'b0;
        #23;
        check("rst_small", {snap_ctl(), bus_s.video_rgb}, '0);
        check("rst_720p", {bus_l.video_hs, bus_l.video_vs, bus_l.video_de, bus_l.busy, bus_l.data_req}, 5'b11000);

        @(negedge pixel_clk) sys_rst_n = 1'b1;
        repeat (5) @(negedge pixel_clk);
        check("idle_no_run", {snap_ctl(), bus_s.video_rgb}, '0);

        bus_s.run = 1'b1;
        wait_fs(4, cyc);
        check("first_fs_latency", cyc, 1);

        cur = 0;
        foreach (vecs[k]) begin
            while (cur < vecs[k].cyc) begin
                @(negedge pixel_clk);
                cur++;
            end
            check($sformatf("vec_cyc%0d", vecs[k].cyc), {snap_ctl(), bus_s.video_rgb}, {vecs[k].ctl, vecs[k].rgb});
        end
        while (cur < FT) begin
            @(negedge pixel_clk);
            cur++;
        end
        check("frame_period", bus_s.frame_start, 1'b1);

        walk_frame("f1", -1, -1, len, de_n, idle);
        check("f1_len", len, FT);
        check("f1_de", de_n, 32);
        check("f1_continues", idle, 1'b0);

        walk_frame("f2_drain", 42, -1, len, de_n, idle);
        check("f2_len", len, FT);
        check("f2_de", de_n, 32);
        check("f2_idle", idle, 1'b1);

        cnt = 0;
        repeat (30) begin
            @(negedge pixel_clk);
            if (bus_s.video_hs || bus_s.video_vs || bus_s.video_de || bus_s.data_req ||
                bus_s.busy || bus_s.frame_start || bus_s.video_rgb != '0) cnt++;
        end
        check("idle_quiet", cnt, 0);

        bus_s.run = 1'b1;
        wait_fs(4, cyc);
        check("restart_latency", cyc, 1);

        walk_frame("f3_rerun", 20, 60, len, de_n, idle);
        check("f3_len", len, FT);
        check("f3_continues", idle, 1'b0);

        repeat (48) @(negedge pixel_clk);
        check("pre_rst_active", {bus_s.video_de, bus_s.data_req}, 2'b11);
        #2 sys_rst_n = 1'b0;
        #1 check("async_rst", {snap_ctl(), bus_s.video_rgb}, '0);
        sb_q.delete();
        @(negedge pixel_clk) sys_rst_n = 1'b1;
        @(negedge pixel_clk);
        check("fs_after_rst", bus_s.frame_start, 1'b1);

        walk_frame("f5_stop", 0, -1, len, de_n, idle);
        check("f5_len", len, FT);
        check("f5_de", de_n, 32);
        check("f5_idle", idle, 1'b1);

        bus_l.run = 1'b1;
        cyc = -1;
        for (int c = 1; c <= 4; c++) begin
            @(negedge pixel_clk);
            if (bus_l.frame_start) begin
                cyc = c;
                break;
            end
        end
        check("l_first_fs", cyc, 1);

        bad = 0;
        hs_low = 0;
        vs_low = 0;
        for (int i = 0; i < L_LINES * 1650; i++) begin
            int h;
            int v;
            h = i % 1650;
            v = i / 1650;
            if ({bus_l.video_hs, bus_l.video_vs, bus_l.video_de, bus_l.data_req, bus_l.busy}
                !== {h >= 40, v >= 5, 1'b0, 1'b0, 1'b1}) bad++;
            if (!bus_l.video_hs) hs_low++;
            if (!bus_l.video_vs) vs_low++;
            @(negedge pixel_clk);
        end
        check("l_sync_trace", bad, 0);
        check("l_hs_low", hs_low, L_LINES * 40);
        check("l_vs_low", vs_low, 5 * 1650);
        bus_l.run = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
